// File: rtl/hack_decode_stage.sv
// Hack CPU decode stage: registers the ROM word, splits A/C fields, drops wrong-path
// words on flush and inserts a one-cycle bubble for the A-then-M read hazard.
module hack_decode_stage #(
    parameter int IL = 16,
    parameter int CW = 16
) (
    input  logic          a_clk,
    input  logic          rst,
    input  logic [IL-1:0] instr,
    input  logic          stall_in,
    input  logic          flush,
    output logic          stall_out,
    output logic          valid,
    output logic          is_a,
    output logic [IL-2:0] a_value,
    output logic [6:0]    comp,
    output logic [2:0]    dest,
    output logic [2:0]    jump,
    output logic          reads_m,
    output logic [CW-1:0] instr_count
);

    logic warm;
    logic hazard_done;
    logic prev_a;
    logic in_c;
    logic haz;

    assign in_c = instr[IL-1];

    // prev_a is set only while the registered word is a valid A-instruction,
    // so it stands in for valid & is_a in the hazard term.
    assign haz = warm & prev_a & in_c & instr[12] & ~hazard_done & ~flush & ~stall_in;
    assign stall_out = stall_in | haz;

    always_ff @(posedge a_clk) begin
        if (!rst) begin
            warm        <= 1'b0;
            hazard_done <= 1'b0;
            prev_a      <= 1'b0;
            valid       <= 1'b0;
            is_a        <= 1'b0;
            a_value     <= '0;
            comp        <= '0;
            dest        <= '0;
            jump        <= '0;
            reads_m     <= 1'b0;
            instr_count <= '0;
        end else begin
            warm <= 1'b1;
            if (flush) begin
                valid       <= 1'b0;
                prev_a      <= 1'b0;
                hazard_done <= 1'b0;
            end else if (!stall_in) begin
                if (haz) begin
                    valid       <= 1'b0;
                    prev_a      <= 1'b0;
                    hazard_done <= 1'b1;
                end else if (warm) begin
                    valid       <= 1'b1;
                    prev_a      <= ~in_c;
                    hazard_done <= 1'b0;
                    is_a        <= ~in_c;
                    a_value     <= in_c ? '0 : instr[IL-2:0];
                    comp        <= in_c ? instr[12:6] : 7'd0;
                    dest        <= in_c ? instr[5:3] : 3'd0;
                    jump        <= in_c ? instr[2:0] : 3'd0;
                    reads_m     <= in_c & instr[12];
                    instr_count <= instr_count + CW'(1);
                end else begin
                    valid  <= 1'b0;
                    prev_a <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/hack_decode_stage.md
Name: hack_decode_stage

Overview:
- Decode stage directly downstream of the instruction ROM/PC fetch stage. Registers the ROM output word and splits it into Hack A/C-instruction fields for the execute stage.
- Drops wrong-path words on flush and inserts a one-cycle bubble for the A-then-M RAM read hazard.
- Drives the fetch stage's stall input and counts issued instructions.

Parameters:
- IL, 16, instruction width in bits; A-instruction value is IL-1 bits wide.
- CW, 16, width of the issued-instruction counter.

Ports:
- a_clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled only at rising edge of a_clk.
- instr  input  IL  instruction word from ROM; valid one cycle after its address was presented.
- stall_in  input  1  downstream (execute/memory) backpressure; hold decode outputs.
- flush  input  1  taken jump resolved in execute; current and incoming words are wrong-path.
- stall_out  output  1  combinational stall to fetch stage.
- valid  output  1  registered; decoded fields below are meaningful.
- is_a  output  1  registered; 1 = A-instruction.
- a_value  output  IL-1  registered; instr[IL-2:0] for A-instructions, 0 for C.
- comp  output  7  registered; {a-bit instr[12], c-bits instr[11:6]}, 0 for A.
- dest  output  3  registered; instr[5:3] (A,D,M), 0 for A.
- jump  output  3  registered; instr[2:0], 0 for A.
- reads_m  output  1  registered; C-instruction with instr[12]=1.
- instr_count  output  CW  registered; count of words issued with valid=1.

Behaviour:
- Reset (rst=0 at edge): valid, is_a, a_value, comp, dest, jump, reads_m, instr_count all 0. Internal warm, hazard_done, prev_a cleared to 0. rst overrides every other input.
- Warm-up: warm=0 for the first edge after rst releases; the instr sampled at that edge is discarded (ROM latency). warm<=1 thereafter.
- Decode: bit IL-1 = 0 means A-instruction, else C-instruction. C-field positions are fixed at bits [12:0] for any IL.
- Hazard: haz = warm & valid & is_a & instr[IL-1] & instr[12] & ~hazard_done & ~flush & ~stall_in (registered valid A-instruction followed by incoming C-instruction that reads M).
- stall_out = stall_in | haz. This is combinational and must never depend on flush except through haz.
- Per-edge priority when rst=1:
  1. flush=1: valid<=0, prev_a<=0, hazard_done<=0. Incoming word dropped; fields may be left unchanged. Counter unchanged.
  2. else stall_in=1: all output registers and hazard_done hold.
  3. else haz=1: valid<=0 (bubble), hazard_done<=1, fields unchanged. Fetch replays the same word next cycle.
  4. else warm=1: load fields from instr, valid<=1, hazard_done<=0, instr_count<=instr_count+1 (wraps at 2^CW-1 to 0).
  5. else (warm=0): valid<=0.
- Hazard bubble length is exactly one cycle. The replayed word issues on the following edge even though the previous registered instruction was an A-instruction, because the bubble has cleared valid.
- Throughput: one word per cycle with no hazard, stall or flush. Latency from instr to fields is 1 cycle.
- stall_in asserted during a hazard bubble: bubble holds (valid=0, hazard_done=1); the word issues on the first edge with stall_in=0.
- flush and stall_in together: flush wins.
- Reset mid-hazard: all state cleared; warm-up repeats.

Test Plan:
- Reset/warm-up: rst=0 for 2 cycles, release, instr=16'h0005 every cycle -> valid=0 one cycle after release, then valid=1, is_a=1, a_value=5, instr_count increments 1,2,3.
- Hazard: issue 16'h0010 (A), then present 16'hFC10 (D=M, a=1) -> stall_out=1 for exactly one cycle, next valid=0. Replay 16'hFC10 -> valid=1, comp=7'h70, dest=3'b010, reads_m=1; count +2 total, not +3.
- No hazard: 16'h0010 then 16'hEC10 (D=A, a=0) -> stall_out stays 0, back-to-back valid, comp=7'h30.
- stall_in: assert for 3 cycles mid-stream -> stall_out=1 all 3 cycles, outputs and instr_count frozen, resume with the next word.
- flush: flush=1 with valid C-instruction jump=3'b111 -> next cycle valid=0, count unchanged. flush during hazard bubble -> hazard_done cleared, no extra stall.
- Counter wrap: CW=4, issue 17 A-instructions -> instr_count reads 15 then 0 then 1.
